instruction_fetch: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It holds the program counter, owns the instruction memory (loadable through a program port), and drives the IF/ID pipeline register consumed by the decode stage: the instruction word and PC+4. It accepts stall and redirect requests from the hazard and branch logic, inserts NOP bubbles on redirect, and stops fetching on a HALT word.

---
 rtl/instruction_fetch.sv | 119 +++++++++++
 tb/tb_instruction_fetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: program counter, loadable instruction memory and the
// IF/ID register, with stall, redirect-with-bubble and HALT handling.
module instruction_fetch #(
  parameter int                    ADDR_BITS  = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 64,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  stall,
  input  logic                  pc_src,
  input  logic [ADDR_BITS-1:0]  branch_target,
  input  logic                  prog_we,
  input  logic [ADDR_BITS-1:0]  prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic [ADDR_BITS-1:0]  next_pc_out,
  output logic [ADDR_BITS-1:0]  pc_out,
  output logic                  valid_out,
  output logic                  halted_out
);

  localparam int IDX_BITS = $clog2(MEM_DEPTH);

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  state_e                state_q,   state_d;
  logic [ADDR_BITS-1:0]  pc_q,      pc_d;
  logic [ADDR_BITS-1:0]  next_pc_q, next_pc_d;
  logic [DATA_WIDTH-1:0] inst_q,    inst_d;
  logic                  valid_q,   valid_d;

  logic [DATA_WIDTH-1:0] fetch_word;
  logic [ADDR_BITS-1:0]  pc_plus4;
  logic [ADDR_BITS-1:0]  target_aligned;
  logic [IDX_BITS-1:0]   prog_idx;
  logic                  unused_bits;

  assign fetch_word     = mem_q[pc_q[IDX_BITS+1:2]];
  assign pc_plus4       = pc_q + ADDR_BITS'(4);
  assign target_aligned = {branch_target[ADDR_BITS-1:2], 2'b00};
  assign prog_idx       = prog_addr[IDX_BITS+1:2];
  // Byte-offset bits and the aliased upper address bits carry no information here.
  assign unused_bits    = ^{branch_target[1:0], prog_addr[1:0],
                            prog_addr[ADDR_BITS-1:IDX_BITS+2]};

  // NOTE: the instruction array has no reset so it maps onto plain RAM and a
  // program loaded before reset survives it.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_idx] <= prog_data;
    end
  end

  // NOTE: every _d gets its hold value first, so no path through the
  // priority chain leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    next_pc_d = next_pc_q;
    inst_d    = inst_q;
    valid_d   = valid_q;

    if (prog_we || !enable) begin
      // Program load and debug freeze both hold the whole stage.
    end else if (pc_src) begin
      pc_d      = target_aligned;
      inst_d    = '0;
      next_pc_d = '0;
      valid_d   = 1'b0;
      state_d   = FETCH;
    end else if (state_q == HALTED) begin
      inst_d    = '0;
      next_pc_d = '0;
      valid_d   = 1'b0;
    end else if (!stall) begin
      inst_d    = fetch_word;
      next_pc_d = pc_plus4;
      valid_d   = 1'b1;
      if (fetch_word == HALT_WORD) begin
        state_d = HALTED;
      end else begin
        pc_d    = pc_plus4;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      next_pc_q <= '0;
      inst_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      next_pc_q <= next_pc_d;
      inst_q    <= inst_d;
      valid_q   <= valid_d;
    end
  end

  assign inst_out    = inst_q;
  assign next_pc_out = next_pc_q;
  assign pc_out      = pc_q;
  assign valid_out   = valid_q;
  assign halted_out  = (state_q == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed program walk-through
// followed by randomized control traffic against a behavioural model.
module tb_instruction_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, enable, stall, pc_src, prog_we;
  logic [31:0] branch_target, prog_addr, prog_data;
  logic [31:0] inst_out, next_pc_out, pc_out;
  logic        valid_out, halted_out;

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .stall        (stall),
    .pc_src       (pc_src),
    .branch_target(branch_target),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .inst_out     (inst_out),
    .next_pc_out  (next_pc_out),
    .pc_out       (pc_out),
    .valid_out    (valid_out),
    .halted_out   (halted_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_mem [64];
  logic [31:0] m_pc = 0, m_inst = 0, m_npc = 0;
  logic        m_valid = 0, m_halted = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr / 4) % 64);
  endfunction

  task automatic make_bubble();
    m_inst  = 0;
    m_npc   = 0;
    m_valid = 0;
  endtask

  // One rising edge worth of the stage's rules, evaluated on current inputs.
  task automatic model_edge();
    logic [31:0] w;
    if (prog_we) m_mem[word_of(prog_addr)] = prog_data;
    if (rst) begin
      m_pc = 0; m_halted = 0;
      make_bubble();
    end else if (prog_we || !enable) begin
      // frozen
    end else if (pc_src) begin
      m_pc = branch_target - (branch_target % 4);
      m_halted = 0;
      make_bubble();
    end else if (m_halted) begin
      make_bubble();
    end else if (!stall) begin
      w       = m_mem[word_of(m_pc)];
      m_inst  = w;
      m_npc   = m_pc + 32'd4;
      m_valid = 1;
      if (w == HALT) m_halted = 1;
      else           m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},     pc_out,      m_pc);
    check({tag, ".inst"},   inst_out,    m_inst);
    check({tag, ".npc"},    next_pc_out, m_npc);
    check({tag, ".valid"},  valid_out,   m_valid);
    check({tag, ".halted"}, halted_out,  m_halted);
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    rst = 0; enable = 1; stall = 0; pc_src = 0; prog_we = 0;
    branch_target = 0; prog_addr = 0; prog_data = 0;
  endtask

  logic [31:0] prog [4] = '{32'h2001_0005, 32'h2002_0003, 32'h0022_1820, 32'hFFFF_FFFF};

  initial begin
    idle_inputs();
    #2;

    // Reset state
    rst = 1;
    tick("reset");
    check("reset.pc_lit", pc_out, 0);
    check("reset.valid_lit", valid_out, 0);

    // Program load (low address bits deliberately noisy)
    rst = 0; enable = 0; prog_we = 1;
    for (int i = 0; i < 64; i++) begin
      prog_addr = (i * 4) | $urandom_range(0, 3);
      prog_data = (i < 4) ? prog[i] : ($urandom() & 32'h7FFF_FFFF);
      tick("load");
    end
    check("load.pc_hold", pc_out, 0);
    prog_we = 0; enable = 1;

    // Straight-line fetch, stall after the 2nd fetch
    tick("f0");
    check("f0.inst", inst_out, 32'h2001_0005);
    check("f0.npc",  next_pc_out, 4);
    check("f0.pc",   pc_out, 4);
    tick("f1");
    check("f1.inst", inst_out, 32'h2002_0003);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick("stall");
      check("stall.inst", inst_out, 32'h2002_0003);
      check("stall.npc",  next_pc_out, 8);
      check("stall.pc",   pc_out, 8);
    end
    stall = 0;
    tick("f2");
    check("f2.inst", inst_out, 32'h0022_1820);
    check("f2.npc",  next_pc_out, 12);
    tick("f3");
    check("halt.inst",   inst_out, HALT);
    check("halt.npc",    next_pc_out, 16);
    check("halt.flag",   halted_out, 1);
    check("halt.pc",     pc_out, 12);
    tick("drain");
    check("drain.valid", valid_out, 0);
    check("drain.pc",    pc_out, 12);

    // Redirect out of HALT
    pc_src = 1; branch_target = 0;
    tick("unhalt");
    check("unhalt.flag", halted_out, 0);
    pc_src = 0;
    tick("restart");
    check("restart.inst", inst_out, 32'h2001_0005);

    // Misaligned branch at pc=4
    pc_src = 1; branch_target = 32'h0000_000A;
    tick("br");
    check("br.pc",    pc_out, 8);
    check("br.valid", valid_out, 0);
    pc_src = 0;
    tick("br_tgt");
    check("br_tgt.inst", inst_out, 32'h0022_1820);
    check("br_tgt.npc",  next_pc_out, 12);

    // Redirect beats stall
    pc_src = 1; stall = 1; branch_target = 4;
    tick("br_stall");
    check("br_stall.pc", pc_out, 4);
    pc_src = 0; stall = 0;
    tick("br_stall2");
    check("br_stall2.inst", inst_out, 32'h2002_0003);

    // enable=0 freezes everything and ignores pc_src
    enable = 0; pc_src = 1; branch_target = 32'h40;
    repeat (2) tick("frozen");
    check("frozen.pc",   pc_out, 8);
    check("frozen.inst", inst_out, 32'h2002_0003);
    enable = 1; pc_src = 0;

    // prog_we during run freezes PC and IF/ID (0x104 aliases mem[1])
    prog_we = 1; prog_addr = 32'h104; prog_data = 32'h1234_5678;
    tick("prog_run");
    check("prog_run.pc", pc_out, 8);
    prog_we = 0;

    // Wrap: branch to the top of the address space
    pc_src = 1; branch_target = 32'hFFFF_FFFF;
    tick("wrap_br");
    check("wrap_br.pc", pc_out, 32'hFFFF_FFFC);
    pc_src = 0;
    tick("wrap63");
    check("wrap63.npc", next_pc_out, 0);
    check("wrap63.pc",  pc_out, 0);
    tick("wrap0");
    check("wrap0.inst", inst_out, 32'h2001_0005);

    // Reset while halted
    pc_src = 1; branch_target = 12;
    tick("to_halt");
    pc_src = 0;
    repeat (2) tick("halting");
    check("pre_rst.halted", halted_out, 1);
    rst = 1;
    tick("rst_halted");
    check("rst_halted.halted", halted_out, 0);
    check("rst_halted.npc",    next_pc_out, 0);
    rst = 0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 63) == 0);
      enable        = ($urandom_range(0, 7) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      pc_src        = ($urandom_range(0, 7) == 0);
      branch_target = ($urandom_range(0, 1) == 0) ? $urandom() : $urandom_range(0, 300);
      prog_we       = !rst && ($urandom_range(0, 15) == 0);
      prog_addr     = $urandom();
      prog_data     = ($urandom_range(0, 7) == 0) ? HALT : $urandom();
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
